// File: rtl/riscv_types.sv
// Shared RISC-V atomic types: AMO opcodes, the agent sequencer state encoding
// and the store-conditional status codes.
package riscv_types;

  typedef enum logic [3:0] {
    AMO_LR   = 4'd0,
    AMO_SC   = 4'd1,
    AMO_SWAP = 4'd2,
    AMO_ADD  = 4'd3,
    AMO_XOR  = 4'd4,
    AMO_AND  = 4'd5,
    AMO_OR   = 4'd6,
    AMO_MIN  = 4'd7,
    AMO_MAX  = 4'd8,
    AMO_MINU = 4'd9,
    AMO_MAXU = 4'd10
  } amo_t;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_RD_REQ  = 3'd1,
    SEQ_RD_WAIT = 3'd2,
    SEQ_ALU     = 3'd3,
    SEQ_WR_REQ  = 3'd4,
    SEQ_SC_CHK  = 3'd5,
    SEQ_RESP    = 3'd6
  } amo_seq_state_t;

  // SC result written back to rd: zero means the store happened.
  localparam logic [31:0] SC_SUCCESS = 32'd0;
  localparam logic [31:0] SC_FAIL    = 32'd1;

endpackage

// File: rtl/amo_agent_sequencer_if.sv
// Bundle of LSU request/response, memory, reservation, shared-ALU and snoop
// signals around one AMO agent sequencer.
interface amo_agent_sequencer_if #(
  parameter int ID_W = 4
);
  import riscv_types::*;

  logic            req_valid;
  logic            req_ready;
  amo_t            req_op;
  logic [31:0]     req_addr;
  logic [31:0]     req_rs2;
  logic [ID_W-1:0] req_id;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_we;
  logic [31:0]     mem_req_addr;
  logic [31:0]     mem_req_wdata;
  logic            mem_rsp_valid;
  logic [31:0]     mem_rdata;

  logic            set_reservation;
  logic            clear_reservation;
  logic [31:0]     reservation;
  logic            reservation_valid;

  logic            rmw_valid;
  logic            rmw_grant;
  amo_t            op;
  logic [31:0]     rs1;
  logic [31:0]     rs2;
  logic [31:0]     rd;

  logic            inv_valid;
  logic [31:0]     inv_addr;

  logic            rsp_valid;
  logic [31:0]     rsp_data;
  logic [ID_W-1:0] rsp_id;
  logic            rsp_err;

  // master is the sequencer itself; slave is the LSU/memory/AMO-unit side.
  modport master (
    input  req_valid, req_op, req_addr, req_rs2, req_id,
    output req_ready,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output set_reservation, clear_reservation, reservation,
    input  reservation_valid,
    output rmw_valid, op, rs1, rs2,
    input  rmw_grant, rd,
    input  inv_valid, inv_addr,
    output rsp_valid, rsp_data, rsp_id, rsp_err
  );

  modport slave (
    output req_valid, req_op, req_addr, req_rs2, req_id,
    input  req_ready,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  set_reservation, clear_reservation, reservation,
    output reservation_valid,
    input  rmw_valid, op, rs1, rs2,
    output rmw_grant, rd,
    output inv_valid, inv_addr,
    input  rsp_valid, rsp_data, rsp_id, rsp_err
  );

endinterface

// File: rtl/amo_agent_sequencer.sv
// Per-agent LR/SC/AMO sequencer: read, shared-ALU cycle, write, one response,
// plus local reservation bookkeeping against snooped external stores.
module amo_agent_sequencer
  import riscv_types::*;
#(
  parameter int ID_W = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  amo_agent_sequencer_if.master bus
);

  localparam logic [2:0] ST_IDLE    = SEQ_IDLE;
  localparam logic [2:0] ST_RD_REQ  = SEQ_RD_REQ;
  localparam logic [2:0] ST_RD_WAIT = SEQ_RD_WAIT;
  localparam logic [2:0] ST_ALU     = SEQ_ALU;
  localparam logic [2:0] ST_WR_REQ  = SEQ_WR_REQ;
  localparam logic [2:0] ST_SC_CHK  = SEQ_SC_CHK;
  localparam logic [2:0] ST_RESP    = SEQ_RESP;

  logic [2:0]      state;
  amo_t            op_q;
  logic [31:0]     addr_q;
  logic [31:0]     rs2_q;
  logic [31:0]     load_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rsp_data_q;
  logic [ID_W-1:0] id_q;
  logic            err_q;
  logic            sc_kill;

  logic inv_hit;
  logic sc_ok;
  logic clear_res;

  assign inv_hit = bus.inv_valid && (bus.inv_addr == addr_q);
  // A snoop landing in the SC_CHK cycle itself must also kill the SC.
  assign sc_ok   = bus.reservation_valid && !sc_kill && !inv_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_q       <= AMO_LR;
      addr_q     <= '0;
      rs2_q      <= '0;
      load_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      id_q       <= '0;
      err_q      <= 1'b0;
      sc_kill    <= 1'b0;
    end else begin
      if (state != ST_IDLE && inv_hit)
        sc_kill <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_q   <= bus.req_op;
            addr_q <= bus.req_addr;
            rs2_q  <= bus.req_rs2;
            id_q   <= bus.req_id;
            err_q  <= (bus.req_addr[1:0] != 2'b00);
            if (bus.req_addr[1:0] != 2'b00) begin
              rsp_data_q <= '0;
              state      <= ST_RESP;
            end else if (bus.req_op == AMO_SC) begin
              state <= ST_SC_CHK;
            end else begin
              state <= ST_RD_REQ;
            end
          end
        end
        ST_RD_REQ: begin
          if (bus.mem_req_ready)
            state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (bus.mem_rsp_valid) begin
            load_q <= bus.mem_rdata;
            if (op_q == AMO_LR) begin
              rsp_data_q <= bus.mem_rdata;
              state      <= ST_RESP;
            end else begin
              state <= ST_ALU;
            end
          end
        end
        ST_ALU: begin
          if (bus.rmw_grant) begin
            wdata_q    <= bus.rd;
            rsp_data_q <= load_q;
            state      <= ST_WR_REQ;
          end
        end
        ST_SC_CHK: begin
          if (sc_ok) begin
            wdata_q    <= rs2_q;
            rsp_data_q <= SC_SUCCESS;
            state      <= ST_WR_REQ;
          end else begin
            rsp_data_q <= SC_FAIL;
            state      <= ST_RESP;
          end
        end
        ST_WR_REQ: begin
          if (bus.mem_req_ready)
            state <= ST_RESP;
        end
        ST_RESP: begin
          sc_kill <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    clear_res = 1'b0;
    case (state)
      ST_IDLE:   clear_res = bus.inv_valid && bus.reservation_valid;
      ST_SC_CHK: clear_res = 1'b1;
      ST_ALU:    clear_res = bus.rmw_grant && bus.reservation_valid;
      default:   clear_res = 1'b0;
    endcase
  end

  assign bus.req_ready = (state == ST_IDLE);

  assign bus.mem_req_valid = (state == ST_RD_REQ) || (state == ST_WR_REQ);
  assign bus.mem_req_we    = (state == ST_WR_REQ);
  assign bus.mem_req_addr  = bus.mem_req_valid ? addr_q : '0;
  assign bus.mem_req_wdata = (state == ST_WR_REQ) ? wdata_q : '0;

  // While idle the AMO unit compares snooped stores against the reservation.
  assign bus.reservation       = (state == ST_IDLE) ? bus.inv_addr : addr_q;
  assign bus.set_reservation   = (state == ST_RD_WAIT) && (op_q == AMO_LR) && bus.mem_rsp_valid;
  assign bus.clear_reservation = clear_res;

  assign bus.rmw_valid = (state == ST_ALU);
  assign bus.op        = (state == ST_ALU) ? op_q : AMO_LR;
  assign bus.rs1       = (state == ST_ALU) ? load_q : '0;
  assign bus.rs2       = (state == ST_ALU) ? rs2_q : '0;

  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_data  = (state == ST_RESP) ? rsp_data_q : '0;
  assign bus.rsp_id    = (state == ST_RESP) ? id_q : '0;
  assign bus.rsp_err   = (state == ST_RESP) && err_q;

endmodule

// File: tb/tb_amo_agent_sequencer.sv
// Directed bench for amo_agent_sequencer: vector table of whole transactions
// against a memory/arbiter model, plus reset and snoop corner sequences.
module tb_amo_agent_sequencer;
  import riscv_types::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  amo_agent_sequencer_if #(.ID_W(4)) bus ();

  amo_agent_sequencer #(.ID_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    amo_t        op;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] mem;
    logic [3:0]  id;
    logic        resv;
    int          gdly;
    int          stall;
    logic        inv_on;
    logic [31:0] e_data;
    logic        e_err;
    int          e_reads;
    int          e_writes;
    logic [31:0] e_wdata;
    int          e_sets;
    int          e_clears;
    int          e_rmw;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  int          o_reads, o_writes, o_sets, o_clears, o_rmw, o_rmw_bad, o_unstable, o_both;
  logic [31:0] o_wdata, o_waddr, o_raddr, o_set_res, o_data;
  logic [3:0]  o_id;
  logic        o_err, o_timeout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu(input amo_t o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      AMO_SWAP: return b;
      AMO_ADD:  return a + b;
      AMO_XOR:  return a ^ b;
      AMO_AND:  return a & b;
      AMO_OR:   return a | b;
      AMO_MIN:  return ($signed(a) < $signed(b)) ? a : b;
      AMO_MAX:  return ($signed(a) > $signed(b)) ? a : b;
      AMO_MINU: return (a < b) ? a : b;
      AMO_MAXU: return (a > b) ? a : b;
      default:  return a;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.req_valid         = 1'b0;
    bus.req_op            = AMO_LR;
    bus.req_addr          = '0;
    bus.req_rs2           = '0;
    bus.req_id            = '0;
    bus.mem_req_ready     = 1'b0;
    bus.mem_rsp_valid     = 1'b0;
    bus.mem_rdata         = '0;
    bus.reservation_valid = 1'b0;
    bus.rmw_grant         = 1'b0;
    bus.rd                = '0;
    bus.inv_valid         = 1'b0;
    bus.inv_addr          = 32'hFFFF_FFF0;
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_txn(input vec_t v);
    int   cyc = 0;
    int   scnt = 0;
    int   gcnt = 0;
    bit   done = 0;
    bit   rsp_pend = 0;
    bit   in_req = 0;
    logic [31:0] h_addr = '0;
    logic [31:0] h_wdata = '0;
    logic        h_we = 1'b0;
    o_reads = 0; o_writes = 0; o_sets = 0; o_clears = 0; o_rmw = 0;
    o_rmw_bad = 0; o_unstable = 0; o_both = 0; o_timeout = 1'b0;
    o_wdata = '0; o_waddr = '0; o_raddr = '0; o_set_res = '0;
    o_data = '0; o_id = '0; o_err = 1'b0;
    while (!done && cyc < 80) begin
      bus.req_valid         = (cyc == 0);
      bus.req_op            = v.op;
      bus.req_addr          = v.addr;
      bus.req_rs2           = v.rs2;
      bus.req_id            = v.id;
      bus.reservation_valid = v.resv;
      bus.mem_rsp_valid     = rsp_pend;
      bus.mem_rdata         = rsp_pend ? v.mem : 32'h0;
      rsp_pend              = 0;
      bus.mem_req_ready     = bus.mem_req_valid && (scnt >= v.stall);
      bus.rmw_grant         = bus.rmw_valid && (gcnt >= v.gdly);
      bus.rd                = alu(bus.op, bus.rs1, bus.rs2);
      bus.inv_valid         = v.inv_on && !bus.req_ready;
      bus.inv_addr          = v.inv_on ? v.addr : 32'hFFFF_FFF0;
      #1;
      if (bus.set_reservation && bus.clear_reservation) o_both++;
      if (bus.set_reservation) begin
        o_sets++;
        o_set_res = bus.reservation;
      end
      if (bus.clear_reservation) o_clears++;
      if (bus.mem_req_valid) begin
        if (!in_req) begin
          h_addr = bus.mem_req_addr; h_wdata = bus.mem_req_wdata; h_we = bus.mem_req_we;
          in_req = 1;
        end else if (h_addr !== bus.mem_req_addr || h_wdata !== bus.mem_req_wdata || h_we !== bus.mem_req_we) begin
          o_unstable++;
        end
        scnt++;
        if (bus.mem_req_ready) begin
          in_req = 0;
          scnt   = 0;
          if (bus.mem_req_we) begin
            o_writes++;
            o_wdata = bus.mem_req_wdata;
            o_waddr = bus.mem_req_addr;
          end else begin
            o_reads++;
            o_raddr  = bus.mem_req_addr;
            rsp_pend = 1;
          end
        end
      end
      if (bus.rmw_valid) begin
        o_rmw++;
        gcnt++;
        if (bus.op !== v.op || bus.rs1 !== v.mem || bus.rs2 !== v.rs2) o_rmw_bad++;
      end
      if (bus.rsp_valid) begin
        done   = 1;
        o_data = bus.rsp_data;
        o_id   = bus.rsp_id;
        o_err  = bus.rsp_err;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    o_timeout = !done;
    idle_inputs();
  endtask

  task automatic check_vec(input int i);
    vec_t v = vecs[i];
    run_txn(v);
    chk($sformatf("v%0d timeout", i), 32'(o_timeout), 32'd0);
    chk($sformatf("v%0d rsp_data", i), o_data, v.e_data);
    chk($sformatf("v%0d rsp_err", i), 32'(o_err), 32'(v.e_err));
    chk($sformatf("v%0d rsp_id", i), 32'(o_id), 32'(v.id));
    chk($sformatf("v%0d reads", i), 32'(o_reads), 32'(v.e_reads));
    chk($sformatf("v%0d writes", i), 32'(o_writes), 32'(v.e_writes));
    if (v.e_reads > 0) chk($sformatf("v%0d read_addr", i), o_raddr, v.addr);
    if (v.e_writes > 0) begin
      chk($sformatf("v%0d write_addr", i), o_waddr, v.addr);
      chk($sformatf("v%0d write_data", i), o_wdata, v.e_wdata);
    end
    chk($sformatf("v%0d set_pulses", i), 32'(o_sets), 32'(v.e_sets));
    if (v.e_sets > 0) chk($sformatf("v%0d set_addr", i), o_set_res, v.addr);
    chk($sformatf("v%0d clear_pulses", i), 32'(o_clears), 32'(v.e_clears));
    chk($sformatf("v%0d rmw_cycles", i), 32'(o_rmw), 32'(v.e_rmw));
    chk($sformatf("v%0d rmw_operands", i), 32'(o_rmw_bad), 32'd0);
    chk($sformatf("v%0d mem_stable", i), 32'(o_unstable), 32'd0);
    chk($sformatf("v%0d set_and_clear", i), 32'(o_both), 32'd0);
    chk($sformatf("v%0d ready_after", i), 32'(bus.req_ready), 32'd1);
    chk($sformatf("v%0d rsp_after", i), 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    //            op        addr          rs2           mem           id    rv gd st inv  e_data        err rd wr e_wdata       set clr rmw
    vecs[0]  = '{AMO_LR,   32'h0000_0100, 32'h0,        32'hDEAD_0001, 4'h1, 1'b0, 0, 0, 1'b0, 32'hDEAD_0001, 1'b0, 1, 0, 32'h0,        1, 0, 0};
    vecs[1]  = '{AMO_SC,   32'h0000_0100, 32'h55,       32'h0,         4'h2, 1'b1, 0, 2, 1'b0, 32'h0,         1'b0, 0, 1, 32'h55,       0, 1, 0};
    vecs[2]  = '{AMO_SC,   32'h0000_0100, 32'h55,       32'h0,         4'h3, 1'b0, 0, 0, 1'b0, 32'h1,         1'b0, 0, 0, 32'h0,        0, 1, 0};
    vecs[3]  = '{AMO_ADD,  32'h0000_0200, 32'h5,        32'h7,         4'h4, 1'b0, 3, 0, 1'b0, 32'h7,         1'b0, 1, 1, 32'hC,        0, 0, 4};
    vecs[4]  = '{AMO_SWAP, 32'h0000_0102, 32'h9,        32'h0,         4'h5, 1'b0, 0, 0, 1'b0, 32'h0,         1'b1, 0, 0, 32'h0,        0, 0, 0};
    vecs[5]  = '{AMO_XOR,  32'h0000_0040, 32'hFF00,     32'hF0F0,      4'h6, 1'b1, 0, 4, 1'b0, 32'hF0F0,      1'b0, 1, 1, 32'h0FF0,     0, 1, 1};
    vecs[6]  = '{AMO_MIN,  32'h0000_0044, 32'h3,        32'hFFFF_FFFE, 4'h7, 1'b0, 0, 1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1, 1, 32'hFFFF_FFFE, 0, 0, 1};
    vecs[7]  = '{AMO_MAXU, 32'h0000_0048, 32'h8000_0000, 32'h5,        4'h8, 1'b0, 0, 0, 1'b0, 32'h5,         1'b0, 1, 1, 32'h8000_0000, 0, 0, 1};
    vecs[8]  = '{AMO_LR,   32'h0000_0300, 32'h0,        32'h3333,      4'h9, 1'b0, 0, 0, 1'b0, 32'h3333,      1'b0, 1, 0, 32'h0,        1, 0, 0};
    vecs[9]  = '{AMO_SC,   32'h0000_0300, 32'hAA,       32'h0,         4'hA, 1'b1, 0, 0, 1'b1, 32'h1,         1'b0, 0, 0, 32'h0,        0, 1, 0};
    vecs[10] = '{AMO_SWAP, 32'h0000_0050, 32'h22,       32'h11,        4'hB, 1'b1, 1, 3, 1'b0, 32'h11,        1'b0, 1, 1, 32'h22,       0, 1, 2};

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("reset rmw_valid", 32'(bus.rmw_valid), 32'd0);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_data", bus.rsp_data, 32'd0);
    chk("reset set_res", 32'(bus.set_reservation), 32'd0);
    chk("reset clear_res", 32'(bus.clear_reservation), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) check_vec(i);

    // Snoop while idle: reservation mirrors inv_addr and a live match is cleared.
    bus.reservation_valid = 1'b1;
    bus.inv_valid         = 1'b1;
    bus.inv_addr          = 32'h0000_0300;
    #1;
    chk("idle_inv clear", 32'(bus.clear_reservation), 32'd1);
    chk("idle_inv reservation", bus.reservation, 32'h0000_0300);
    chk("idle_inv set", 32'(bus.set_reservation), 32'd0);
    bus.inv_valid = 1'b0;
    #1;
    chk("idle_noinv clear", 32'(bus.clear_reservation), 32'd0);
    idle_inputs();
    @(posedge clk);
    #1;

    // Reset while a read is outstanding; memory never returns the data.
    bus.req_valid = 1'b1;
    bus.req_op    = AMO_LR;
    bus.req_addr  = 32'h0000_0500;
    bus.req_id    = 4'hC;
    @(posedge clk);
    #1;
    bus.req_valid     = 1'b0;
    bus.mem_req_ready = 1'b1;
    chk("rst_mid rd_req", 32'(bus.mem_req_valid), 32'd1);
    @(posedge clk);
    #1;
    bus.mem_req_ready = 1'b0;
    chk("rst_mid rd_wait busy", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_mid req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mid mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_mid set_res", 32'(bus.set_reservation), 32'd0);
    chk("rst_mid clear_res", 32'(bus.clear_reservation), 32'd0);
    chk("rst_mid rsp_valid", 32'(bus.rsp_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_mid no_rsp%0d", k), 32'(bus.rsp_valid), 32'd0);
    end
    check_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
